// File: rtl/thor2024_rf_wrbuf.sv
// Commit write buffer in front of the register-file RAM write port: two in-order
// pushes per clock, one RAM write per clock, byte-granular forwarding of in-flight writes.
module thor2024_rf_wrbuf #(
    parameter int WID  = 64,
    parameter int DEP  = 256,
    parameter int QDEP = 8,
    localparam int AW  = $clog2(DEP),
    localparam int BW  = WID / 8,
    localparam int PW  = $clog2(QDEP),
    localparam int CW  = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr0_v,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [WID-1:0]  wr0_data,
    input  logic [BW-1:0]   wr0_be,
    input  logic            wr1_v,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [WID-1:0]  wr1_data,
    input  logic [BW-1:0]   wr1_be,
    output logic            wr_rdy,
    output logic            ram_ena,
    output logic [BW-1:0]   ram_wea,
    output logic [AW-1:0]   ram_addra,
    output logic [WID-1:0]  ram_dina,
    input  logic [AW-1:0]   fwd_addr,
    output logic            fwd_hit,
    output logic [BW-1:0]   fwd_be,
    output logic [WID-1:0]  fwd_data,
    output logic [CW-1:0]   count,
    output logic            ovf
);

    localparam logic [PW-1:0] ONE_P = PW'(1);

    logic [AW-1:0]  addr_q [QDEP];
    logic [WID-1:0] data_q [QDEP];
    logic [BW-1:0]  be_q   [QDEP];

    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, tail1_s;
    logic           ovf_q, ovf_d;
    logic           ram_ena_q;
    logic [BW-1:0]  ram_wea_q;
    logic [AW-1:0]  ram_addra_q;
    logic [WID-1:0] ram_dina_q;

    logic           p0_s, p1_s, push0_s, push1_s, drop_s, pop_s, wr_rdy_s;
    logic [CW-1:0]  npush_s;

    // Push/pop decisions; a push into an empty queue is not popped in the same cycle.
    always_comb begin
        p0_s     = wr0_v && (wr0_be != {BW{1'b0}});
        p1_s     = wr1_v && (wr1_be != {BW{1'b0}});
        wr_rdy_s = (count_q <= CW'(QDEP - 2));
        push0_s  = p0_s && wr_rdy_s;
        push1_s  = p1_s && wr_rdy_s;
        drop_s   = (p0_s || p1_s) && !wr_rdy_s;
        pop_s    = (count_q != {CW{1'b0}});
        tail1_s  = push0_s ? tail_q + ONE_P : tail_q;
        npush_s  = CW'(push0_s) + CW'(push1_s);
        count_d  = count_q + npush_s - CW'(pop_s);
        head_d   = pop_s ? head_q + ONE_P : head_q;
        tail_d   = tail_q + npush_s[PW-1:0];
        ovf_d    = ovf_q | drop_s;
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
        end
    end

    // Queue storage; slot 1 lands right behind slot 0 when both push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < QDEP; k++) begin
                addr_q[k] <= {AW{1'b0}};
                data_q[k] <= {WID{1'b0}};
                be_q[k]   <= {BW{1'b0}};
            end
        end else begin
            if (push0_s) begin
                addr_q[tail_q] <= wr0_addr;
                data_q[tail_q] <= wr0_data;
                be_q[tail_q]   <= wr0_be;
            end
            if (push1_s) begin
                addr_q[tail1_s] <= wr1_addr;
                data_q[tail1_s] <= wr1_data;
                be_q[tail1_s]   <= wr1_be;
            end
        end
    end

    // RAM port registers; address and data hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena_q   <= 1'b0;
            ram_wea_q   <= {BW{1'b0}};
            ram_addra_q <= {AW{1'b0}};
            ram_dina_q  <= {WID{1'b0}};
        end else if (pop_s) begin
            ram_ena_q   <= 1'b1;
            ram_wea_q   <= be_q[head_q];
            ram_addra_q <= addr_q[head_q];
            ram_dina_q  <= data_q[head_q];
        end else begin
            ram_ena_q   <= 1'b0;
            ram_wea_q   <= {BW{1'b0}};
        end
    end

    logic [BW-1:0]  fbe_s;
    logic [WID-1:0] fdat_s;
    logic [PW-1:0]  idx_s;
    logic           live_s;

    // Forwarding: walk candidates oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        fbe_s  = {BW{1'b0}};
        fdat_s = {WID{1'b0}};
        idx_s  = head_q;
        live_s = ram_ena_q && (ram_addra_q == fwd_addr);
        for (int i = 0; i < BW; i++) begin
            fbe_s[i]        = (live_s && ram_wea_q[i]) ? 1'b1 : fbe_s[i];
            fdat_s[i*8 +: 8] = (live_s && ram_wea_q[i]) ? ram_dina_q[i*8 +: 8] : fdat_s[i*8 +: 8];
        end
        for (int k = 0; k < QDEP; k++) begin
            idx_s  = head_q + PW'(k);
            live_s = (CW'(k) < count_q) && (addr_q[idx_s] == fwd_addr);
            for (int i = 0; i < BW; i++) begin
                fbe_s[i]         = (live_s && be_q[idx_s][i]) ? 1'b1 : fbe_s[i];
                fdat_s[i*8 +: 8] = (live_s && be_q[idx_s][i]) ? data_q[idx_s][i*8 +: 8] : fdat_s[i*8 +: 8];
            end
        end
    end

    assign wr_rdy    = wr_rdy_s;
    assign ram_ena   = ram_ena_q;
    assign ram_wea   = ram_wea_q;
    assign ram_addra = ram_addra_q;
    assign ram_dina  = ram_dina_q;
    assign fwd_be    = fbe_s;
    assign fwd_hit   = |fbe_s;
    assign fwd_data  = fdat_s;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_thor2024_rf_wrbuf.sv
// Directed bench for thor2024_rf_wrbuf: vector table for single/dual/zero-be cases,
// hand sequences for fill/drain, overflow and asynchronous reset.
module tb_thor2024_rf_wrbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr0_v, wr1_v;
    logic [7:0]  wr0_addr, wr1_addr, wr0_be, wr1_be;
    logic [63:0] wr0_data, wr1_data;
    logic        wr_rdy, ram_ena, fwd_hit, ovf;
    logic [7:0]  ram_wea, ram_addra, fwd_addr, fwd_be;
    logic [63:0] ram_dina, fwd_data;
    logic [3:0]  count;

    thor2024_rf_wrbuf #(.WID(64), .DEP(256), .QDEP(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_v(wr0_v), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
        .wr1_v(wr1_v), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
        .wr_rdy(wr_rdy), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dina(ram_dina), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_be(fwd_be),
        .fwd_data(fwd_data), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w0v; logic [7:0] w0a; logic [63:0] w0d; logic [7:0] w0be;
        logic        w1v; logic [7:0] w1a; logic [63:0] w1d; logic [7:0] w1be;
        logic [7:0]  fa;
        logic [3:0]  e_cnt; logic e_ena; logic [7:0] e_wea; logic [7:0] e_adr; logic [63:0] e_din;
        logic        e_hit; logic [7:0] e_fbe; logic [63:0] e_fd; logic e_rdy;
    } vec_t;

    typedef struct { logic [7:0] a; logic [7:0] be; logic [63:0] d; } wr_t;

    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] DA = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] DB = 64'hBBBBBBBBBBBBBBBB;
    localparam logic [63:0] DC = 64'hCCCCCCCCCCCCCCCC;
    localparam logic [63:0] D5 = 64'h5555555555555555;

    vec_t tv [10];
    wr_t  expq [$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    logic exp_ovf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        wr0_v = 1'b0; wr0_addr = 8'd0; wr0_data = 64'd0; wr0_be = 8'h00;
        wr1_v = 1'b0; wr1_addr = 8'd0; wr1_data = 64'd0; wr1_be = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // tick and compare any RAM write against the expected in-order write stream
    task automatic tick_mon();
        wr_t e;
        tick();
        if (ram_ena === 1'b1) begin
            if (expq.size() == 0) begin
                chk("ram_unexpected_write", 64'(ram_addra), 64'hFFFF);
            end else begin
                e = expq.pop_front();
                chk("ram_addra", 64'(ram_addra), 64'(e.a));
                chk("ram_wea", 64'(ram_wea), 64'(e.be));
                chk("ram_dina", ram_dina, e.d);
            end
        end
    endtask

    task automatic fill(input int n, input int base);
        wr_t w;
        for (int c = 0; c < n; c++) begin
            wr0_v = 1'b1; wr0_addr = 8'(base + 2*c); wr0_be = 8'hFF;
            wr0_data = {8{8'(base + c)}};
            wr1_v = 1'b1; wr1_addr = 8'(base + 2*c + 1); wr1_be = 8'(8'hF0 >> (c % 4));
            wr1_data = ~{8{8'(base + c)}};
            w.a = wr0_addr; w.be = wr0_be; w.d = wr0_data; expq.push_back(w);
            w.a = wr1_addr; w.be = wr1_be; w.d = wr1_data; expq.push_back(w);
            tick_mon();
            exp_cnt = exp_cnt + 2 - ((exp_cnt != 0) ? 1 : 0);
            chk("fill_count", 64'(count), 64'(exp_cnt));
            chk("fill_wr_rdy", 64'(wr_rdy), 64'(exp_cnt <= 6));
            chk("fill_ovf", 64'(ovf), 64'(exp_ovf));
        end
        idle();
    endtask

    task automatic drain();
        int guard = 0;
        idle();
        while (exp_cnt != 0 && guard < 20) begin
            tick_mon();
            exp_cnt = exp_cnt - 1;
            guard++;
            chk("drain_count", 64'(count), 64'(exp_cnt));
        end
        tick_mon();
        chk("drain_ram_ena_off", 64'(ram_ena), 64'd0);
        chk("drain_all_issued", 64'(expq.size()), 64'd0);
        chk("drain_ovf", 64'(ovf), 64'(exp_ovf));
    endtask

    initial begin
        tv[0] = '{1'b1, 8'd5, D1, 8'hFF, 1'b0, 8'd0, 64'd0, 8'h00, 8'd5,
                  4'd1, 1'b0, 8'h00, 8'd0, 64'd0, 1'b1, 8'hFF, D1, 1'b1};
        tv[1] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd5,
                  4'd0, 1'b1, 8'hFF, 8'd5, D1, 1'b1, 8'hFF, D1, 1'b1};
        tv[2] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd5,
                  4'd0, 1'b0, 8'h00, 8'd5, D1, 1'b0, 8'h00, 64'd0, 1'b1};
        tv[3] = '{1'b1, 8'd7, DA, 8'h0F, 1'b1, 8'd7, DB, 8'h03, 8'd7,
                  4'd2, 1'b0, 8'h00, 8'd5, D1, 1'b1, 8'h0F, 64'h00000000AAAABBBB, 1'b1};
        tv[4] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd7,
                  4'd1, 1'b1, 8'h0F, 8'd7, DA, 1'b1, 8'h0F, 64'h00000000AAAABBBB, 1'b1};
        tv[5] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd7,
                  4'd0, 1'b1, 8'h03, 8'd7, DB, 1'b1, 8'h03, 64'h000000000000BBBB, 1'b1};
        tv[6] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd7,
                  4'd0, 1'b0, 8'h00, 8'd7, DB, 1'b0, 8'h00, 64'd0, 1'b1};
        tv[7] = '{1'b1, 8'd9, D5, 8'h00, 1'b1, 8'd3, DC, 8'h80, 8'd3,
                  4'd1, 1'b0, 8'h00, 8'd7, DB, 1'b1, 8'h80, 64'hCC00000000000000, 1'b1};
        tv[8] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd9,
                  4'd0, 1'b1, 8'h80, 8'd3, DC, 1'b0, 8'h00, 64'd0, 1'b1};
        tv[9] = '{1'b0, 8'd0, 64'd0, 8'h00, 1'b0, 8'd0, 64'd0, 8'h00, 8'd3,
                  4'd0, 1'b0, 8'h00, 8'd3, DC, 1'b0, 8'h00, 64'd0, 1'b1};

        rst_n = 1'b0;
        idle();
        fwd_addr = 8'd0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ram_ena", 64'(ram_ena), 64'd0);
        chk("rst_ram_wea", 64'(ram_wea), 64'd0);
        chk("rst_ram_addra", 64'(ram_addra), 64'd0);
        chk("rst_ram_dina", ram_dina, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst_fwd_be", 64'(fwd_be), 64'd0);
        chk("rst_fwd_data", fwd_data, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            wr0_v = tv[v].w0v; wr0_addr = tv[v].w0a; wr0_data = tv[v].w0d; wr0_be = tv[v].w0be;
            wr1_v = tv[v].w1v; wr1_addr = tv[v].w1a; wr1_data = tv[v].w1d; wr1_be = tv[v].w1be;
            fwd_addr = tv[v].fa;
            tick();
            chk($sformatf("v%0d_count", v), 64'(count), 64'(tv[v].e_cnt));
            chk($sformatf("v%0d_ram_ena", v), 64'(ram_ena), 64'(tv[v].e_ena));
            chk($sformatf("v%0d_ram_wea", v), 64'(ram_wea), 64'(tv[v].e_wea));
            chk($sformatf("v%0d_ram_addra", v), 64'(ram_addra), 64'(tv[v].e_adr));
            chk($sformatf("v%0d_ram_dina", v), ram_dina, tv[v].e_din);
            chk($sformatf("v%0d_fwd_hit", v), 64'(fwd_hit), 64'(tv[v].e_hit));
            chk($sformatf("v%0d_fwd_be", v), 64'(fwd_be), 64'(tv[v].e_fbe));
            chk($sformatf("v%0d_fwd_data", v), fwd_data, tv[v].e_fd);
            chk($sformatf("v%0d_wr_rdy", v), 64'(wr_rdy), 64'(tv[v].e_rdy));
            chk($sformatf("v%0d_ovf", v), 64'(ovf), 64'd0);
        end
        idle();

        // fill to the ready threshold, then drain back to empty
        exp_cnt = 0;
        fill(6, 16);
        drain();

        // overflow: a push while not ready is dropped and ovf sticks
        fill(6, 64);
        wr0_v = 1'b1; wr0_addr = 8'd100; wr0_data = 64'hDEADBEEFDEADBEEF; wr0_be = 8'hFF;
        wr1_v = 1'b1; wr1_addr = 8'd101; wr1_data = 64'hFEEDFACEFEEDFACE; wr1_be = 8'h0F;
        tick_mon();
        idle();
        exp_cnt = exp_cnt - 1;
        exp_ovf = 1'b1;
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_count", 64'(count), 64'(exp_cnt));
        chk("ovf_wr_rdy", 64'(wr_rdy), 64'd1);
        drain();

        // asynchronous reset with five entries queued and a write in the output register
        fill(4, 128);
        chk("pre_rst_count", 64'(count), 64'd5);
        chk("pre_rst_ram_ena", 64'(ram_ena), 64'd1);
        #2;
        fwd_addr = 8'd131;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_ram_ena", 64'(ram_ena), 64'd0);
        chk("arst_ram_wea", 64'(ram_wea), 64'd0);
        chk("arst_ram_addra", 64'(ram_addra), 64'd0);
        chk("arst_ram_dina", ram_dina, 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("arst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("arst_fwd_be", 64'(fwd_be), 64'd0);
        chk("arst_fwd_data", fwd_data, 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("arst_hold_ram_ena", 64'(ram_ena), 64'd0);
        end
        #2;
        rst_n = 1'b1;
        expq.delete();
        exp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick_mon();
            chk("post_rst_count", 64'(count), 64'd0);
            chk("post_rst_ram_ena", 64'(ram_ena), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
